// File: rtl/fetch_stage.sv
// fetch_stage -- front-end fetch stage of the tartaruga core.
//
// Owns the fetch PC, presents it to instruction memory (combinational read
// in the same cycle) and captures {pc, instr} pairs into an in-order fetch
// queue that feeds decode over a valid/ready handshake. A redirect flushes
// the queue and reloads the PC from the resolved target.
//
// Optional feature: define FETCH_PERF_CNT_EN to add the perf_fetched_o and
// perf_full_stall_o counter ports.
//
// Ports:
//   clk_i             core clock
//   rst_i             synchronous active-high reset
//   imem_pc_o         fetch address (always pc_q)
//   imem_instr_i      instruction word for imem_pc_o, same cycle
//   redirect_valid_i  redirect pulse; highest priority below reset
//   redirect_pc_i     redirect target (low two bits ignored)
//   decode_valid_o    queue head valid
//   decode_pc_o       PC of queue head
//   decode_instr_o    instruction at queue head
//   decode_ready_i    decode consumes head when valid && ready
//   fq_count_o        queue occupancy
//   perf_fetched_o    (optional) number of pushes, wraps
//   perf_full_stall_o (optional) cycles stalled on a full queue, wraps
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FQ_DEPTH = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  output logic [31:0]                 imem_pc_o,
  input  logic [31:0]                 imem_instr_i,
  input  logic                        redirect_valid_i,
  input  logic [31:0]                 redirect_pc_i,
  output logic                        decode_valid_o,
  output logic [31:0]                 decode_pc_o,
  output logic [31:0]                 decode_instr_o,
  input  logic                        decode_ready_i,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]                 perf_fetched_o,
  output logic [31:0]                 perf_full_stall_o,
`endif
  output logic [$clog2(FQ_DEPTH):0]   fq_count_o
);

  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(FQ_DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

  fq_entry_t [FQ_DEPTH-1:0] fq_q;
  logic [PW-1:0]            head_q, tail_q;
  logic [CW-1:0]            count_q;
  logic [31:0]              pc_q;

  logic pop, push, full;

  assign full = (count_q == FULL);
  assign pop  = decode_valid_o && decode_ready_i;
  // A pop frees a slot in the same cycle, so a full queue can still accept;
  // this puts decode_ready_i on the pc_q enable path by design.
  assign push = !redirect_valid_i && (!full || pop);

  assign imem_pc_o      = pc_q;
  assign decode_valid_o = (count_q != '0);
  assign decode_pc_o    = fq_q[head_q].pc;
  assign decode_instr_o = fq_q[head_q].instr;
  assign fq_count_o     = count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      fq_q    <= '0;
    end else if (redirect_valid_i) begin
      // Flush: any same-cycle pop is dropped, not delivered.
      pc_q    <= {redirect_pc_i[31:2], 2'b00};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        fq_q[tail_q] <= '{pc: pc_q, instr: imem_instr_i};
        tail_q       <= tail_q + 1'b1;
        pc_q         <= pc_q + 32'd4;
      end
      if (pop) head_q <= head_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_full_stall_q;

  // Counters survive redirects; only reset clears them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_fetched_q    <= '0;
      perf_full_stall_q <= '0;
    end else begin
      if (push) perf_fetched_q <= perf_fetched_q + 32'd1;
      if (full && !pop && !redirect_valid_i)
        perf_full_stall_q <= perf_full_stall_q + 32'd1;
    end
  end

  assign perf_fetched_o    = perf_fetched_q;
  assign perf_full_stall_o = perf_full_stall_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset state, in-order delivery,
// backpressure and full-with-pop, redirect flush, PC wrap, mid-stream reset.
module tb_fetch_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] imem_pc_o;
  logic [31:0] imem_instr_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        decode_valid_o;
  logic [31:0] decode_pc_o;
  logic [31:0] decode_instr_o;
  logic        decode_ready_i;
  logic [2:0]  fq_count_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_o;
  logic [31:0] perf_full_stall_o;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk_i = ~clk_i;

  fetch_stage #(.RESET_PC(32'h0), .FQ_DEPTH(4)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .imem_pc_o        (imem_pc_o),
    .imem_instr_i     (imem_instr_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .decode_valid_o   (decode_valid_o),
    .decode_pc_o      (decode_pc_o),
    .decode_instr_o   (decode_instr_o),
    .decode_ready_i   (decode_ready_i),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetched_o   (perf_fetched_o),
    .perf_full_stall_o(perf_full_stall_o),
`endif
    .fq_count_o       (fq_count_o)
  );

  // Instruction memory contents: two fixed words, everything else derived
  // from the address so each fetched word is distinguishable.
  function automatic logic [31:0] imem_word(input logic [31:0] pc);
    case (pc)
      32'h0:   imem_word = 32'h456790b7;
      32'h4:   imem_word = 32'h90108093;
      default: imem_word = pc ^ 32'hDEAD_0000;
    endcase
  endfunction

  assign imem_instr_i = imem_word(imem_pc_o);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    redirect_valid_i = 1'b0;
    step();
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; redirect_valid_i = 1'b0; redirect_pc_i = '0; decode_ready_i = 1'b0;
    step(2);
    // Reset state
    check("rst_valid", 32'(decode_valid_o), 32'd0);
    check("rst_pc",    decode_pc_o,         32'h0);
    check("rst_instr", decode_instr_o,      32'h0);
    check("rst_count", 32'(fq_count_o),     32'd0);
    check("rst_imem",  imem_pc_o,           32'h0);

    // Release with decode always ready
    rst_i = 1'b0; decode_ready_i = 1'b1;
    step();
    check("c1_valid", 32'(decode_valid_o), 32'd1);
    check("c1_pc",    decode_pc_o,         32'h0);
    check("c1_instr", decode_instr_o,      32'h456790b7);
    step();
    check("c2_pc",    decode_pc_o,         32'h4);
    check("c2_instr", decode_instr_o,      32'h90108093);
    check("c2_count", 32'(fq_count_o),     32'd1);

    // Backpressure for 10 cycles from a fresh reset
    do_reset();
    decode_ready_i = 1'b0;
    step(10);
    check("bp_count", 32'(fq_count_o), 32'd4);
    check("bp_imem",  imem_pc_o,       32'h10);
    check("bp_pc",    decode_pc_o,     32'h0);
    check("bp_instr", decode_instr_o,  32'h456790b7);
    // Raise ready: full queue pops and pushes in the same cycle
    decode_ready_i = 1'b1;
    step();
    check("fp_count", 32'(fq_count_o), 32'd4);
    check("fp_imem",  imem_pc_o,       32'h14);
    check("dr_pc4",   decode_pc_o,     32'h4);
    step();
    check("dr_pc8",   decode_pc_o,     32'h8);
    step();
    check("dr_pcC",   decode_pc_o,     32'hC);
    step();
    check("dr_valid10", 32'(decode_valid_o), 32'd1);
    check("dr_pc10",    decode_pc_o,         32'h10);
    check("dr_instr10", decode_instr_o,      32'h10 ^ 32'hDEAD_0000);

    // Redirect with 3 entries queued and ready=1
    do_reset();
    decode_ready_i = 1'b0;
    step(3);
    check("rd_pre_count", 32'(fq_count_o), 32'd3);
    decode_ready_i = 1'b1;
    redirect_valid_i = 1'b1; redirect_pc_i = 32'h0000_0103;
    step();
    redirect_valid_i = 1'b0;
    check("rd_count", 32'(fq_count_o),     32'd0);
    check("rd_valid", 32'(decode_valid_o), 32'd0);
    check("rd_imem",  imem_pc_o,           32'h100);
    step();
    check("rd_valid2", 32'(decode_valid_o), 32'd1);
    check("rd_pc",     decode_pc_o,         32'h100);
    check("rd_instr",  decode_instr_o,      32'h100 ^ 32'hDEAD_0000);
    step();
    check("rd_pc2",    decode_pc_o,         32'h104);

    // PC wrap-around
    redirect_valid_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    step();
    redirect_valid_i = 1'b0;
    check("wr_imem", imem_pc_o, 32'hFFFF_FFFC);
    step();
    check("wr_pc_hi", decode_pc_o, 32'hFFFF_FFFC);
    check("wr_imem0", imem_pc_o,   32'h0);
    step();
    check("wr_pc_lo",    decode_pc_o,    32'h0);
    check("wr_instr_lo", decode_instr_o, 32'h456790b7);

    // Reset mid-stream with a full queue
    decode_ready_i = 1'b0;
    step(6);
    check("mr_pre_count", 32'(fq_count_o), 32'd4);
    do_reset();
    check("mr_valid", 32'(decode_valid_o), 32'd0);
    check("mr_count", 32'(fq_count_o),     32'd0);
    check("mr_imem",  imem_pc_o,           32'h0);
`ifdef FETCH_PERF_CNT_EN
    check("mr_perf_fetched", perf_fetched_o,    32'd0);
    check("mr_perf_stall",   perf_full_stall_o, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Front-end fetch stage of the tartaruga core.
- Owns the architectural fetch PC and drives it to the instruction memory, which returns the word combinationally in the same cycle.
- Captures {pc, instr} pairs into a small in-order fetch queue that feeds decode over a valid/ready handshake.
- Accepts redirects from branch/jump resolution; a redirect flushes the queue and reloads the PC.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset; bits [1:0] must be 0.
- FQ_DEPTH, 4, fetch queue entries; power of two, minimum 2.

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  synchronous, active-high reset.
- imem_pc_o  out  32 (bus32_t)  fetch address to instruction memory; always equals pc_q.
- imem_instr_i  in  32 (bus32_t)  instruction word for imem_pc_o, valid in the same cycle.
- redirect_valid_i  in  1  redirect request, single-cycle pulse.
- redirect_pc_i  in  32  redirect target.
- decode_valid_o  out  1  queue head is valid.
- decode_pc_o  out  32  PC of the queue head.
- decode_instr_o  out  32  instruction at the queue head.
- decode_ready_i  in  1  decode consumes the head when valid && ready.
- fq_count_o  out  $clog2(FQ_DEPTH)+1  current queue occupancy.

Behaviour:
- All state updates on posedge clk_i.
- When rst_i=1:
  - pc_q <= RESET_PC.
  - Queue head/tail pointers and count cleared; every entry's storage cleared to 0.
  - Outputs after reset: decode_valid_o=0, decode_pc_o=0, decode_instr_o=0, fq_count_o=0, imem_pc_o=RESET_PC.
  - Reset asserted mid-operation discards all queued entries and any redirect presented in that cycle.
- Event definitions:
  - pop = decode_valid_o && decode_ready_i.
  - push = !redirect_valid_i && (count < FQ_DEPTH || pop).
- Push: writes {pc_q, imem_instr_i} at the tail and sets pc_q <= pc_q + 4.
- Full queue with a simultaneous pop: push is permitted, so the occupancy stays at FQ_DEPTH. This creates a combinational path from decode_ready_i to the pc_q enable, and that path is accepted.
- Full queue with no pop: no push and pc_q holds. imem_pc_o stays stable, so the same word is re-read next cycle.
- Redirect has the highest priority (below reset):
  - Count, head and tail are all cleared.
  - pc_q <= {redirect_pc_i[31:2], 2'b00}.
  - No push occurs, and a pop in the same cycle is ignored: the head is flushed, not delivered.
  - First fetch from the target occurs in cycle N+1; the earliest decode_valid_o for the target is cycle N+2.
- Latency: an instruction fetched in cycle N is visible on decode_* in cycle N+1 (registered queue, head read combinationally from storage).
- Steady state, with decode always ready: one instruction per cycle, no bubbles.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag.
- Pointers wrap modulo FQ_DEPTH. Count is tracked separately so that full and empty are unambiguous.
- decode_pc_o and decode_instr_o hold their values while decode_valid_o && !decode_ready_i; the head is stable until popped or flushed.
- decode_* contents are don't-care when decode_valid_o=0.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, two extra ports are added:
  - perf_fetched_o (out, 32): count of pushes.
  - perf_full_stall_o (out, 32): count of cycles with count==FQ_DEPTH && !pop && !redirect_valid_i.
- Both counters are 32-bit, wrap on overflow, and are cleared by rst_i only; a redirect does not clear them.
- When undefined, the ports and counters do not exist and core behaviour is identical.

Test Plan:
- Reset release, RESET_PC=0, imem returns 32'h456790b7 @0 and 32'h90108093 @4, decode_ready_i=1:
  - Cycle 1 after reset: decode_valid_o=1, pc=0, instr=32'h456790b7.
  - Cycle 2: pc=4, instr=32'h90108093.
- Backpressure, decode_ready_i=0 for 10 cycles:
  - fq_count_o saturates at 4 and imem_pc_o holds at 32'h10.
  - Head stays {0, 32'h456790b7}.
  - Raise ready: entries 0, 4, 8, 0xC drain in order, then 0x10 follows with no gap.
- Full queue with pop on the same cycle: fq_count_o stays 4 and imem_pc_o advances by 4.
- Redirect to 32'h0000_0103 while the queue holds 3 entries and ready=1:
  - Next cycle: fq_count_o=0, decode_valid_o=0, imem_pc_o=32'h100.
  - Following cycle: decode_pc_o=32'h100.
- Wrap-around: redirect to 32'hFFFF_FFFC; decode sees pc 32'hFFFF_FFFC, then 32'h0000_0000.
- Reset mid-stream (rst_i=1 for one cycle with the queue full):
  - Next cycle: decode_valid_o=0, fq_count_o=0, imem_pc_o=RESET_PC.
  - With FETCH_PERF_CNT_EN defined, both perf counters read 0.
